// File: rtl/ptp_pkg.sv
// Shared widths and byte-lane helper for the ptp_bridge byte/word bridge.
package ptp_pkg;

  localparam int BYTE_W_DEF = 8;
  localparam int WORD_W_DEF = 32;

  // Bit offset of the byte that a serializer index selects within its word.
  function automatic int lane_lsb(input int idx, input int nb, input int byte_w);
    return (idx % nb) * byte_w;
  endfunction

endpackage

// File: rtl/ptp_edge_det.sv
// Rising-edge detector for a level strobe that is already synchronous to clk.
module ptp_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic ctrl_i,
  output logic rise_o
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = ctrl_i;
  end

  // A cleared history makes a strobe that is already high at reset release count as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign rise_o = ctrl_i & ~prev_q;

endmodule

// File: rtl/ptp_bridge.sv
// Byte packer and two-word byte serializer between the 8-bit pin side and the 32-bit datapath.
// Optional parity outputs are enabled by defining PTP_PARITY_EN.
module ptp_bridge
  import ptp_pkg::*;
#(
  parameter  int BYTE_W = BYTE_W_DEF,
  parameter  int WORD_W = WORD_W_DEF,
  localparam int NB     = WORD_W / BYTE_W,
  localparam int IDX_W  = $clog2(2 * NB),
  localparam int CNT_W  = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pack_ctrl_i,
  input  logic              pack_clr_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              ser_ctrl_i,
  input  logic              ser_clr_i,
  input  logic [WORD_W-1:0] word_a_i,
  input  logic [WORD_W-1:0] word_b_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic [IDX_W-1:0]  byte_idx_o
`ifdef PTP_PARITY_EN
  ,
  output logic              parity_o,
  output logic              word_parity_o
`endif
);

  logic              pack_step;
  logic              ser_step;

  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  int                lane;

  ptp_edge_det u_pack_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctrl_i (pack_ctrl_i),
    .rise_o (pack_step)
  );

  ptp_edge_det u_ser_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctrl_i (ser_ctrl_i),
    .rise_o (ser_step)
  );

  always_comb begin
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    idx_d   = idx_q;

    // Clear wins over a coincident step so the absorbed byte never lands in the word.
    if (pack_clr_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (pack_step) begin
      word_d  = {word_q[WORD_W-BYTE_W-1:0], byte_i};
      valid_d = (cnt_q == CNT_W'(NB - 1));
      cnt_d   = valid_d ? '0 : cnt_q + 1'b1;
    end

    if (ser_clr_i) begin
      idx_d = '0;
    end else if (ser_step) begin
      idx_d = (idx_q == IDX_W'(2 * NB - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  // Live word inputs feed straight through the mux, so they show up in the same cycle.
  always_comb begin
    lane = lane_lsb(int'(idx_q), NB, BYTE_W);
    if (int'(idx_q) < NB) byte_o = word_a_i[lane +: BYTE_W];
    else                  byte_o = word_b_i[lane +: BYTE_W];
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign byte_idx_o   = idx_q;

`ifdef PTP_PARITY_EN
  logic word_parity_q, word_parity_d;

  always_comb begin
    word_parity_d = ^word_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) word_parity_q <= 1'b0;
    else        word_parity_q <= word_parity_d;
  end

  assign parity_o      = ^byte_o;
  assign word_parity_o = word_parity_q;
`endif

endmodule

// File: tb/tb_ptp_bridge.sv
// Self-checking bench for ptp_bridge: directed scenarios plus random traffic against a behavioural model.
module tb_ptp_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pack_ctrl_i, pack_clr_i, ser_ctrl_i, ser_clr_i;
  logic [7:0]  byte_i;
  logic [31:0] word_a_i, word_b_i;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic [7:0]  byte_o;
  logic [2:0]  byte_idx_o;
`ifdef PTP_PARITY_EN
  logic        parity_o, word_parity_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference state
  logic [31:0] m_word;
  int          m_cnt, m_idx;
  logic        m_valid, m_pprev, m_sprev;

  ptp_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pack_ctrl_i  (pack_ctrl_i),
    .pack_clr_i   (pack_clr_i),
    .byte_i       (byte_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .ser_ctrl_i   (ser_ctrl_i),
    .ser_clr_i    (ser_clr_i),
    .word_a_i     (word_a_i),
    .word_b_i     (word_b_i),
    .byte_o       (byte_o),
    .byte_idx_o   (byte_idx_o)
`ifdef PTP_PARITY_EN
    ,
    .parity_o     (parity_o),
    .word_parity_o(word_parity_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_word = 0; m_cnt = 0; m_valid = 0; m_pprev = 0; m_sprev = 0; m_idx = 0;
    end else begin
      m_valid = 0;
      if (pack_clr_i) begin
        m_word = 0; m_cnt = 0;
      end else if (pack_ctrl_i && !m_pprev) begin
        m_word = (m_word << 8) | 32'(byte_i);
        m_cnt  = (m_cnt + 1) % 4;
        m_valid = (m_cnt == 0);
      end
      if (ser_clr_i) m_idx = 0;
      else if (ser_ctrl_i && !m_sprev) m_idx = (m_idx + 1) % 8;
      m_pprev = pack_ctrl_i;
      m_sprev = ser_ctrl_i;
    end
  end

  function automatic logic [7:0] exp_byte();
    logic [31:0] w;
    w = (m_idx < 4) ? word_a_i : word_b_i;
    return 8'((w >> (8 * (m_idx % 4))) & 32'hFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_byte(input logic [7:0] b);
    byte_i = b; pack_ctrl_i = 1'b1; tick();
    pack_ctrl_i = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pack_ctrl_i = 0; pack_clr_i = 0; ser_ctrl_i = 0; ser_clr_i = 0;
    byte_i = 8'h00; word_a_i = $urandom; word_b_i = $urandom;
    tick(); tick();
    rst_n = 1'b1; tick();
    n_checks++; if (word_o !== 32'h0) begin n_fail++; $display("FAIL reset_word got=%h want=0", word_o); end
    n_checks++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", word_valid_o); end
    n_checks++; if (byte_idx_o !== 3'd0) begin n_fail++; $display("FAIL reset_idx got=%0d want=0", byte_idx_o); end
    n_checks++; if (byte_o !== word_a_i[7:0]) begin n_fail++; $display("FAIL reset_byte got=%h want=%h", byte_o, word_a_i[7:0]); end
    $display("test_reset: word=%h idx=%0d byte=%h", word_o, byte_idx_o, byte_o);
  endtask

  task automatic test_pack_seq();
    logic [7:0] seq [4];
    int pulses;
    seq[0] = 8'h12; seq[1] = 8'h34; seq[2] = 8'h56; seq[3] = 8'h78;
    pulses = 0;
    pack_clr_i = 1'b1; tick(); pack_clr_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      byte_i = seq[i]; pack_ctrl_i = 1'b1; tick();
      n_checks++; if (word_valid_o !== (i == 3)) begin n_fail++; $display("FAIL pack_valid_step%0d got=%b want=%b", i, word_valid_o, (i == 3)); end
      if (word_valid_o === 1'b1) pulses++;
      pack_ctrl_i = 1'b0; tick();
      n_checks++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL pack_valid_after%0d got=%b want=0", i, word_valid_o); end
    end
    n_checks++; if (word_o !== 32'h12345678) begin n_fail++; $display("FAIL pack_word got=%h want=12345678", word_o); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL pack_pulses got=%0d want=1", pulses); end
    $display("test_pack_seq: word=%h pulses=%0d", word_o, pulses);
  endtask

  task automatic test_hold();
    pack_clr_i = 1'b1; tick(); pack_clr_i = 1'b0;
    byte_i = 8'hAA; pack_ctrl_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    pack_ctrl_i = 1'b0; tick();
    n_checks++; if (word_o !== 32'h000000AA) begin n_fail++; $display("FAIL hold_word got=%h want=000000aa", word_o); end
    $display("test_hold: word=%h", word_o);
  endtask

  task automatic test_serialize();
    logic [7:0] want;
    word_a_i = 32'h03020100; word_b_i = 32'h07060504;
    ser_clr_i = 1'b1; tick(); ser_clr_i = 1'b0;
    n_checks++; if (byte_o !== 8'h00) begin n_fail++; $display("FAIL ser_byte0 got=%h want=00", byte_o); end
    for (int k = 1; k <= 9; k++) begin
      ser_ctrl_i = 1'b1; tick(); ser_ctrl_i = 1'b0; tick();
      want = 8'(k % 8);
      n_checks++; if (byte_o !== want) begin n_fail++; $display("FAIL ser_byte%0d got=%h want=%h", k, byte_o, want); end
      $display("test_serialize: strobe=%0d idx=%0d byte=%h", k, byte_idx_o, byte_o);
    end
  endtask

  task automatic test_clr_collision();
    int pulses;
    pack_clr_i = 1'b1; tick(); pack_clr_i = 1'b0;
    pack_byte(8'hC1); pack_byte(8'hC2);
    byte_i = 8'hEE; pack_clr_i = 1'b1; pack_ctrl_i = 1'b1; tick();
    n_checks++; if (word_o !== 32'h0) begin n_fail++; $display("FAIL clr_word got=%h want=0", word_o); end
    n_checks++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL clr_valid got=%b want=0", word_valid_o); end
    pack_clr_i = 1'b0; pack_ctrl_i = 1'b0; tick();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      byte_i = 8'($urandom); pack_ctrl_i = 1'b1; tick();
      if (word_valid_o === 1'b1) pulses++;
      n_checks++; if (word_valid_o !== (i == 3)) begin n_fail++; $display("FAIL clr_refill_valid%0d got=%b want=%b", i, word_valid_o, (i == 3)); end
      pack_ctrl_i = 1'b0; tick();
    end
    n_checks++; if (word_o !== m_word) begin n_fail++; $display("FAIL clr_refill_word got=%h want=%h", word_o, m_word); end
    $display("test_clr_collision: word=%h pulses=%0d", word_o, pulses);
  endtask

  task automatic test_reset_mid();
    pack_clr_i = 1'b1; ser_clr_i = 1'b1; tick(); pack_clr_i = 1'b0; ser_clr_i = 1'b0;
    pack_byte(8'h11); pack_byte(8'h22); pack_byte(8'h33);
    for (int i = 0; i < 5; i++) begin ser_ctrl_i = 1'b1; tick(); ser_ctrl_i = 1'b0; tick(); end
    n_checks++; if (byte_idx_o !== 3'd5) begin n_fail++; $display("FAIL mid_idx_pre got=%0d want=5", byte_idx_o); end
    rst_n = 1'b0; byte_i = 8'h44; pack_ctrl_i = 1'b1; tick();
    n_checks++; if (word_o !== 32'h0) begin n_fail++; $display("FAIL mid_word got=%h want=0", word_o); end
    n_checks++; if (byte_idx_o !== 3'd0) begin n_fail++; $display("FAIL mid_idx got=%0d want=0", byte_idx_o); end
    n_checks++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%b want=0", word_valid_o); end
    rst_n = 1'b1; pack_ctrl_i = 1'b0; tick();
    n_checks++; if (word_o !== 32'h0 || word_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_release got=%h/%b want=0/0", word_o, word_valid_o); end
    $display("test_reset_mid: word=%h idx=%0d", word_o, byte_idx_o);
  endtask

  task automatic test_strobe_at_release();
    rst_n = 1'b0; pack_ctrl_i = 1'b1; byte_i = 8'h5A; tick();
    rst_n = 1'b1; tick();
    n_checks++; if (word_o !== 32'h0000005A) begin n_fail++; $display("FAIL release_edge got=%h want=0000005a", word_o); end
    pack_ctrl_i = 1'b0; tick();
    $display("test_strobe_at_release: word=%h", word_o);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      pack_ctrl_i = 1'($urandom); ser_ctrl_i = 1'($urandom);
      pack_clr_i  = ($urandom_range(0, 15) == 0); ser_clr_i = ($urandom_range(0, 15) == 0);
      byte_i = 8'($urandom);
      if ($urandom_range(0, 3) == 0) word_a_i = $urandom;
      if ($urandom_range(0, 3) == 0) word_b_i = $urandom;
      tick();
      n_checks++;
      if (word_o !== m_word || word_valid_o !== m_valid || byte_idx_o !== 3'(m_idx) || byte_o !== exp_byte()) begin
        n_fail++;
        $display("FAIL rand_cycle%0d got=%h/%b/%0d/%h want=%h/%b/%0d/%h", c, word_o, word_valid_o, byte_idx_o, byte_o,
                 m_word, m_valid, m_idx, exp_byte());
      end
`ifdef PTP_PARITY_EN
      n_checks++;
      if (parity_o !== ^exp_byte() || word_parity_o !== ^m_word) begin
        n_fail++;
        $display("FAIL rand_parity%0d got=%b/%b want=%b/%b", c, parity_o, word_parity_o, ^exp_byte(), ^m_word);
      end
`endif
    end
    $display("test_random: word=%h idx=%0d", word_o, byte_idx_o);
  endtask

  initial begin
    test_reset();
    test_pack_seq();
    test_hold();
    test_serialize();
    test_clr_collision();
    test_reset_mid();
    test_strobe_at_release();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ptp_bridge.md
Name: ptp_bridge

Overview:
- Byte/word bridge between the 8-bit Tiny Tapeout pin interface and the 32-bit Manchester Baby datapath. Used by tt_um_arkis_manchester_baby.
- Packer half (ptp_a function): assembles successive input bytes into a 32-bit word.
- Serializer half (ptp_b function): presents two 32-bit words one byte at a time.
- Both halves are stepped by externally driven control strobes, which are edge-detected against the single system clock.

Parameters:
- BYTE_W, 8, width of the byte-side bus.
- WORD_W, 32, word width; must be a multiple of BYTE_W; bytes per word NB = WORD_W/BYTE_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- pack_ctrl_i  in  1  packer step strobe (level input, rising-edge detected).
- pack_clr_i  in  1  synchronous clear of packer word and count.
- byte_i  in  BYTE_W  byte to shift in.
- word_o  out  WORD_W  packed word.
- word_valid_o  out  1  one-cycle pulse when NB bytes have been packed.
- ser_ctrl_i  in  1  serializer step strobe (rising-edge detected).
- ser_clr_i  in  1  synchronous clear of serializer index.
- word_a_i  in  WORD_W  first word to serialize.
- word_b_i  in  WORD_W  second word to serialize.
- byte_o  out  BYTE_W  currently selected byte.
- byte_idx_o  out  log2(2*NB)  current byte index.

Behaviour:
- Reset (rst_n low at a clk edge):
  - word_o = 0, word_valid_o = 0, byte_o index = 0, byte_idx_o = 0.
  - Edge-detect history registers = 0, so a strobe already high when reset releases counts as a rising edge.
- Edge detect:
  - Each control input has its own previous-value register, updated every cycle.
  - Step event = ctrl high AND prev low, evaluated at a clk edge.
  - A strobe held high yields exactly one step.
  - Minimum strobe high/low time is one clk period.
  - Control inputs are assumed synchronous to clk; there is no internal synchronizer.
- Packer:
  - On a step: word <= {word[WORD_W-BYTE_W-1:0], byte_i}, i.e. the shift is left.
  - The first byte of a group ends in word[31:24] after NB steps.
  - A 2-bit count increments on each step.
  - On the step that completes NB bytes (count NB-1 -> 0): word_valid_o = 1 for the following cycle only.
  - word_o is registered and visible the cycle after the step edge.
  - After wrap the word is not cleared: further steps keep shifting and the count restarts.
  - pack_clr_i high: word and count = 0, no valid pulse. Clear has priority over a simultaneous step.
- Serializer:
  - Index range 0..2*NB-1.
  - Index 0..NB-1 selects word_a_i byte idx, where byte k is bits [8k+7:8k]. Index NB..2NB-1 selects word_b_i byte (idx-NB).
  - On a step: index increments, wrapping 2NB-1 -> 0.
  - byte_o is a combinational mux of the registered index and the live word inputs. Input changes appear in the same cycle.
  - ser_clr_i resets the index to 0 and has priority over a step.
- Packer and serializer are fully independent; simultaneous events on both halves are each honoured in the same cycle.
- Reset mid-operation discards any partial word and returns the index to 0.

Optional Feature:
- Macro PTP_PARITY_EN.
- Defined: adds output parity_o (1 bit) = XOR of byte_o bits (even-parity bit, combinational). Also adds output word_parity_o = XOR of word_o bits, registered with word_o.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package ptp_pkg: BYTE_W/WORD_W defaults, NB, index width, byte-select function.
- One natural sub-module: ptp_edge_det (prev register + rising-edge pulse, synchronous active-low reset), instantiated twice.

Test Plan:
- Reset then idle: word_o=0, word_valid_o=0, byte_idx_o=0, byte_o=word_a_i[7:0].
- Pack 0x12, 0x34, 0x56, 0x78 with one strobe each -> word_o=0x12345678; word_valid_o pulses once, only after the fourth step.
- Hold pack_ctrl_i high 5 cycles with byte_i=0xAA -> exactly one shift; word_o=0x000000AA.
- word_a_i=0x03020100, word_b_i=0x07060504, 9 ser strobes:
  - byte_o before the strobes = 0x00.
  - After strobes 1..7, byte_o = 0x01..0x07.
  - After the 9th strobe (index wraps to 0 on the 8th), byte_o = 0x01.
- pack_clr_i and a pack step in the same cycle after 2 bytes -> word_o=0, count 0; the next 4 bytes produce a full word and a valid pulse.
- rst_n low mid-pack (after 3 bytes) and mid-serialize (index 5) -> word_o=0, index 0, no valid pulse.
